core_scheduler: RTL and testbench
=================================

Name: core_scheduler

Overview:
Per-core control FSM that sequences fetch, decode, memory, execute and update for one block of threads. It drives the shared core_state seen by the fetcher, decoder, LSUs, ALUs and per-thread PC units. At UPDATE it selects the converged next PC from the per-thread PC units, and it flags divergence because branch divergence is unsupported. It also counts retired instructions.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes in the core
PROGRAM_MEM_ADDR_BITS, 8, program counter width
COUNT_BITS, 16, retired-instruction counter width

Ports:
clk  in  1  core clock; the only clock
reset  in  1  reset, asynchronous and active-high
start  in  1  launch block execution; only honoured in IDLE
thread_enable  in  THREADS_PER_BLOCK  active-lane mask; captured on start
decoded_mem_read_enable  in  1  current instruction is LDR
decoded_mem_write_enable  in  1  current instruction is STR
decoded_ret  in  1  current instruction is RET
fetcher_state  in  3  IDLE=000, FETCHING=001, FETCHED=010
lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i]; IDLE=00, REQUESTING=01, WAITING=10, DONE=11
next_pc  in  PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK  per-lane next PC, flat, lane i in slice i
core_state  out  3  IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111
current_pc  out  PROGRAM_MEM_ADDR_BITS  PC broadcast to fetcher and PC units
done  out  1  block finished; high while in DONE
divergence_error  out  1  sticky; enabled lanes disagreed on next PC
instr_count  out  COUNT_BITS  retired instructions, saturating

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): core_state=IDLE, current_pc=0, done=0, divergence_error=0, instr_count=0, lane mask register=0.
- IDLE:
  - start=1 with a nonzero thread_enable: capture the mask, set current_pc=0, move to FETCH.
  - start=1 with a zero mask: go straight to DONE.
  - start is ignored in every other state.
- FETCH: hold until fetcher_state==FETCHED, then go to DECODE. There is no timeout.
- DECODE: exactly 1 cycle, then REQUEST.
- REQUEST: exactly 1 cycle, then WAIT. The LSUs latch their requests during this state.
- WAIT:
  - busy = any masked lane with lsu_state==REQUESTING or WAITING. Lanes outside the mask are ignored.
  - Exit to EXECUTE in the first cycle busy==0.
  - For non-memory instructions busy is 0, so WAIT lasts 1 cycle.
  - LSU DONE (11) counts as not busy.
- EXECUTE: exactly 1 cycle, then UPDATE. The PC units register next_pc at the end of this cycle, so next_pc is valid throughout UPDATE.
- UPDATE (1 cycle):
  - instr_count increments, saturating at all-ones.
  - decoded_ret=1: go to DONE and set done=1. RET takes priority; the divergence check is skipped.
  - Otherwise, sel = next_pc of the lowest-index masked lane, and current_pc<=sel.
  - If any masked lane's next_pc != sel: divergence_error<=1 and go to DONE with done=1.
  - If all lanes agree: go to FETCH.
- DONE: core_state=111 and done=1. Held until reset; the block is re-armed only by reset.
- PC wrap (255+1 -> 0) happens in the PC units; the scheduler adopts the wrapped value with no special casing.
- Minimum latency per non-memory instruction: FETCH(>=1) + DECODE + REQUEST + WAIT + EXECUTE + UPDATE = 6 cycles when FETCHED is seen on the first FETCH cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- core_pkg:
  - core_state, fetcher_state and lsu_state encodings as localparams/typedefs, shared with the fetcher, LSU and PC units.
  - Width constants.
- One sub-module, pc_converge: combinational. Takes the mask and the flat next_pc. Produces sel_pc (lowest masked lane), any_lane and diverged. It is instantiated once in core_scheduler.

Test Plan:
- Reset, mask=4'b1111, start pulse, fetcher reports FETCHED after 2 cycles, all lanes next_pc=1, decoded_ret=0 -> states 001,001,010,011,100,101,110. current_pc becomes 1 at the end of UPDATE and instr_count=1.
- LDR with lane 2 showing lsu_state REQUESTING then WAITING for 5 cycles, lane 3 (masked off) stuck at WAITING -> WAIT lasts exactly 6 cycles, then EXECUTE.
- mask=4'b0110, lanes 1/2 next_pc=8'h2A, lanes 0/3 next_pc=8'hFF -> current_pc=8'h2A, divergence_error stays 0.
- mask=4'b1111, lane 3 next_pc=5 while the others are 4 -> divergence_error=1, done=1, core_state=111.
- decoded_ret=1 in UPDATE with mismatched next_pc -> done=1, divergence_error=0. start pulse in DONE -> no state change.
- Assert reset mid-WAIT, start with mask=0 -> all outputs return to their reset values immediately. The second start goes directly to DONE with instr_count=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the core control path: scheduler, fetcher, LSUs and PC units.
package core_pkg;

    localparam int unsigned CORE_STATE_W    = 3;
    localparam int unsigned FETCHER_STATE_W = 3;
    localparam int unsigned LSU_STATE_W     = 2;

    typedef enum logic [CORE_STATE_W-1:0] {
        CoreIdle    = 3'b000,
        CoreFetch   = 3'b001,
        CoreDecode  = 3'b010,
        CoreRequest = 3'b011,
        CoreWait    = 3'b100,
        CoreExecute = 3'b101,
        CoreUpdate  = 3'b110,
        CoreDone    = 3'b111
    } core_state_e;

    typedef enum logic [FETCHER_STATE_W-1:0] {
        FetchIdle     = 3'b000,
        FetchFetching = 3'b001,
        FetchFetched  = 3'b010
    } fetcher_state_e;

    typedef enum logic [LSU_STATE_W-1:0] {
        LsuIdle       = 2'b00,
        LsuRequesting = 2'b01,
        LsuWaiting    = 2'b10,
        LsuDone       = 2'b11
    } lsu_state_e;

    function automatic logic lsu_busy(input logic [LSU_STATE_W-1:0] s);
        return (s == LsuRequesting) || (s == LsuWaiting);
    endfunction

endpackage

// File: rtl/pc_converge.sv
// Picks the next PC of the lowest-index enabled lane and flags any enabled lane that disagrees.
module pc_converge #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned PC_BITS = 8
) (
    input  logic [LANES-1:0]         mask_i,
    input  logic [PC_BITS*LANES-1:0] next_pc_i,
    output logic [PC_BITS-1:0]       sel_pc_o,
    output logic                     any_lane_o,
    output logic                     diverged_o
);

    always_comb begin
        sel_pc_o   = '0;
        diverged_o = 1'b0;
        any_lane_o = |mask_i;
        // Walk downwards so the lowest enabled lane is the last writer.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                sel_pc_o = next_pc_i[i*PC_BITS +: PC_BITS];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (mask_i[i] && (next_pc_i[i*PC_BITS +: PC_BITS] != sel_pc_o)) begin
                diverged_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences fetch/decode/memory/execute/update for one thread block,
// converges the per-lane next PC, flags divergence and counts retired instructions.
module core_scheduler
    import core_pkg::*;
#(
    parameter int unsigned THREADS_PER_BLOCK     = 4,
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned COUNT_BITS            = 16
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
    input  logic                                               decoded_mem_read_enable,
    input  logic                                               decoded_mem_write_enable,
    input  logic                                               decoded_ret,
    input  logic [2:0]                                         fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                                         core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
    output logic                                               done,
    output logic                                               divergence_error,
    output logic [COUNT_BITS-1:0]                              instr_count
);

    core_state_e                      state_q, state_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
    logic                             div_q, div_d;
    logic [COUNT_BITS-1:0]            cnt_q, cnt_d;
    logic [THREADS_PER_BLOCK-1:0]     mask_q, mask_d;

    logic [PROGRAM_MEM_ADDR_BITS-1:0] sel_pc;
    logic                             any_lane;
    logic                             diverged;
    logic                             busy;

    pc_converge #(
        .LANES  (THREADS_PER_BLOCK),
        .PC_BITS(PROGRAM_MEM_ADDR_BITS)
    ) u_pc_converge (
        .mask_i    (mask_q),
        .next_pc_i (next_pc),
        .sel_pc_o  (sel_pc),
        .any_lane_o(any_lane),
        .diverged_o(diverged)
    );

    // LSUs only act on LDR/STR; lanes outside the block mask never hold up WAIT.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask_q[i] && lsu_busy(lsu_state[2*i +: 2])) begin
                busy = 1'b1;
            end
        end
        busy = busy & (decoded_mem_read_enable | decoded_mem_write_enable);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        unique case (state_q)
            CoreIdle: begin
                if (start) begin
                    mask_d  = thread_enable;
                    pc_d    = '0;
                    state_d = (|thread_enable) ? CoreFetch : CoreDone;
                end
            end
            CoreFetch: begin
                if (fetcher_state == FetchFetched) begin
                    state_d = CoreDecode;
                end
            end
            CoreDecode:  state_d = CoreRequest;
            CoreRequest: state_d = CoreWait;
            CoreWait: begin
                if (!busy) begin
                    state_d = CoreExecute;
                end
            end
            CoreExecute: state_d = CoreUpdate;
            CoreUpdate: begin
                if (cnt_q != {COUNT_BITS{1'b1}}) begin
                    cnt_d = cnt_q + COUNT_BITS'(1);
                end
                if (decoded_ret) begin
                    state_d = CoreDone;
                end else begin
                    pc_d = sel_pc;
                    if (diverged) begin
                        div_d   = 1'b1;
                        state_d = CoreDone;
                    end else if (any_lane) begin
                        state_d = CoreFetch;
                    end else begin
                        state_d = CoreDone;
                    end
                end
            end
            CoreDone: state_d = CoreDone;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CoreIdle;
            pc_q    <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    assign core_state       = state_q;
    assign current_pc       = pc_q;
    assign done             = (state_q == CoreDone);
    assign divergence_error = div_q;
    assign instr_count      = cnt_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: per-instruction timeline model driving random traffic, checked every cycle.
module tb_core_scheduler;

    localparam int T  = 4;
    localparam int PB = 8;
    localparam int CB = 4;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [T-1:0]      thread_enable;
    logic              decoded_mem_read_enable;
    logic              decoded_mem_write_enable;
    logic              decoded_ret;
    logic [2:0]        fetcher_state;
    logic [2*T-1:0]    lsu_state;
    logic [PB*T-1:0]   next_pc;
    logic [2:0]        core_state;
    logic [PB-1:0]     current_pc;
    logic              done;
    logic              divergence_error;
    logic [CB-1:0]     instr_count;

    always #5 clk = ~clk;

    core_scheduler #(
        .THREADS_PER_BLOCK    (T),
        .PROGRAM_MEM_ADDR_BITS(PB),
        .COUNT_BITS           (CB)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .thread_enable           (thread_enable),
        .decoded_mem_read_enable (decoded_mem_read_enable),
        .decoded_mem_write_enable(decoded_mem_write_enable),
        .decoded_ret             (decoded_ret),
        .fetcher_state           (fetcher_state),
        .lsu_state               (lsu_state),
        .next_pc                 (next_pc),
        .core_state              (core_state),
        .current_pc              (current_pc),
        .done                    (done),
        .divergence_error        (divergence_error),
        .instr_count             (instr_count)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic [PB-1:0] pc;
        logic [CB-1:0] cnt;
        logic          div;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   wait_seen = 0;

    // Model: architectural values that hold until the next UPDATE retires.
    logic [PB-1:0] m_pc;
    logic [CB-1:0] m_cnt;
    logic          m_div;
    logic          m_done;
    logic [T-1:0]  m_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_state == S_WAIT) wait_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("core_state", 32'(core_state), 32'(e.st));
                check("current_pc", 32'(current_pc), 32'(e.pc));
                check("instr_count", 32'(instr_count), 32'(e.cnt));
                check("divergence_error", 32'(divergence_error), 32'(e.div));
                check("done", 32'(done), 32'(e.st == S_DONE));
            end
        end
    end

    task automatic push(input logic [2:0] st);
        exp_t e;
        e.st  = st;
        e.pc  = m_pc;
        e.cnt = m_cnt;
        e.div = m_div;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = '0; m_cnt = '0; m_div = 1'b0; m_done = 1'b0; m_mask = '0;
        fetcher_state = 3'b000; lsu_state = '0; decoded_ret = 1'b0;
        decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        model_reset();
        push(S_IDLE);
        next_cycle();
        reset = 1'b0;
        push(S_IDLE);
    endtask

    task automatic launch(input logic [T-1:0] mask);
        next_cycle();
        start = 1'b1;
        thread_enable = mask;
        push(S_IDLE);
        m_mask = mask;
        m_pc = '0;
        if (mask == '0) m_done = 1'b1;
    endtask

    task automatic fetch_wait_cycle();
        next_cycle();
        fetcher_state = 3'b001;
        push(S_FETCH);
    endtask

    task automatic done_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            start = 1'($urandom % 2);
            thread_enable = T'($urandom);
            push(S_DONE);
        end
    endtask

    // One instruction: plan the whole timeline up front, drive it, then retire it in the model.
    task automatic run_instr(input int fd, input int mem, input int busy[T],
                             input logic [PB-1:0] pcs[T], input logic ret, input bit abort);
        int            wlen;
        logic [2*T-1:0] l;
        logic [PB-1:0] sel;
        bit            found;
        bit            dv;
        wlen = 1;
        for (int i = 0; i < T; i++)
            if (m_mask[i] && busy[i] + 1 > wlen) wlen = busy[i] + 1;
        for (int k = 0; k < fd; k++) begin
            next_cycle();
            decoded_mem_read_enable  = (mem == 1);
            decoded_mem_write_enable = (mem == 2);
            decoded_ret = ret;
            for (int i = 0; i < T; i++) next_pc[i*PB +: PB] = pcs[i];
            fetcher_state = (k == fd - 1) ? 3'b010 : 3'b001;
            lsu_state = (2*T)'($urandom);
            push(S_FETCH);
        end
        next_cycle();
        fetcher_state = 3'b000;
        lsu_state = (2*T)'($urandom);
        push(S_DECODE);
        next_cycle();
        push(S_REQUEST);
        for (int k = 0; k < wlen; k++) begin
            next_cycle();
            if (abort && k == 2) begin
                reset = 1'b1;
                #1;
                check("abort_state", 32'(core_state), 32'(0));
                check("abort_pc", 32'(current_pc), 32'(0));
                check("abort_cnt", 32'(instr_count), 32'(0));
                check("abort_done", 32'(done), 32'(0));
                check("abort_div", 32'(divergence_error), 32'(0));
                model_reset();
                return;
            end
            for (int i = 0; i < T; i++)
                l[2*i +: 2] = (k < busy[i]) ? ((k == 0) ? 2'b01 : 2'b10)
                                            : ((mem != 0) ? 2'b11 : 2'b00);
            lsu_state = l;
            push(S_WAIT);
        end
        next_cycle();
        lsu_state = (2*T)'($urandom);
        push(S_EXECUTE);
        next_cycle();
        push(S_UPDATE);
        if (m_cnt != {CB{1'b1}}) m_cnt = m_cnt + CB'(1);
        if (ret) begin
            m_done = 1'b1;
        end else begin
            found = 0;
            sel = '0;
            dv = 0;
            for (int i = 0; i < T; i++)
                if (m_mask[i] && !found) begin sel = pcs[i]; found = 1; end
            for (int i = 0; i < T; i++)
                if (m_mask[i] && pcs[i] != sel) dv = 1;
            m_pc = sel;
            if (dv) begin m_div = 1'b1; m_done = 1'b1; end
        end
    endtask

    initial begin
        int            b[T];
        int            z[T];
        logic [PB-1:0] p[T];
        logic [T-1:0]  mask;
        logic [PB-1:0] base;
        reset = 1'b1; start = 1'b0; thread_enable = '0; next_pc = '0;
        model_reset();
        z = '{0, 0, 0, 0};

        // Converging program, fetch takes two cycles.
        do_reset();
        check("reset_state", 32'(core_state), 32'(0));
        check("reset_pc", 32'(current_pc), 32'(0));
        launch(4'b1111);
        p = '{8'h01, 8'h01, 8'h01, 8'h01};
        run_instr(2, 0, z, p, 1'b0, 1'b0);
        fetch_wait_cycle();
        check("s1_pc", 32'(current_pc), 32'h01);
        check("s1_cnt", 32'(instr_count), 32'd1);

        // LDR: lane 2 busy for 5 cycles, masked-off lane 3 stuck waiting.
        do_reset();
        launch(4'b0111);
        b = '{0, 0, 5, 99};
        p = '{8'h02, 8'h02, 8'h02, 8'h02};
        wait_seen = 0;
        run_instr(1, 1, b, p, 1'b0, 1'b0);
        check("s2_wait_len", 32'(wait_seen), 32'd6);

        // Partial mask picks lane 1; unmasked lanes disagree harmlessly.
        do_reset();
        launch(4'b0110);
        p = '{8'hFF, 8'h2A, 8'h2A, 8'hFF};
        run_instr(1, 0, z, p, 1'b0, 1'b0);
        fetch_wait_cycle();
        check("s3_pc", 32'(current_pc), 32'h2A);
        check("s3_div", 32'(divergence_error), 32'd0);

        // Divergence.
        do_reset();
        launch(4'b1111);
        p = '{8'h04, 8'h04, 8'h04, 8'h05};
        run_instr(2, 0, z, p, 1'b0, 1'b0);
        done_cycles(1);
        check("s4_div", 32'(divergence_error), 32'd1);
        check("s4_done", 32'(done), 32'd1);
        check("s4_state", 32'(core_state), 32'd7);

        // RET overrides divergence; start in DONE is ignored.
        do_reset();
        launch(4'b1111);
        b = '{1, 2, 0, 3};
        p = '{8'h01, 8'h09, 8'h03, 8'h07};
        run_instr(1, 2, b, p, 1'b1, 1'b0);
        next_cycle();
        start = 1'b1;
        thread_enable = 4'b1111;
        push(S_DONE);
        done_cycles(1);
        check("s5_done", 32'(done), 32'd1);
        check("s5_div", 32'(divergence_error), 32'd0);
        check("s5_state", 32'(core_state), 32'd7);
        check("s5_cnt", 32'(instr_count), 32'd1);

        // Reset mid-WAIT, then a zero-mask start.
        do_reset();
        launch(4'b1111);
        p = '{8'h03, 8'h03, 8'h03, 8'h03};
        run_instr(1, 0, z, p, 1'b0, 1'b0);
        b = '{3, 4, 3, 3};
        run_instr(1, 1, b, p, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b0;
        push(S_IDLE);
        launch(4'b0000);
        done_cycles(2);
        check("s6_cnt", 32'(instr_count), 32'd0);
        check("s6_state", 32'(core_state), 32'd7);

        // Counter saturation after 18 retirements.
        do_reset();
        launch(4'b1011);
        for (int n = 0; n < 18; n++) begin
            base = PB'($urandom);
            p = '{base, base, base, base};
            run_instr(1, 0, z, p, 1'b0, 1'b0);
        end
        fetch_wait_cycle();
        check("s7_sat", 32'(instr_count), 32'hF);

        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int k = 0; k < int'($urandom % 3); k++) begin
                next_cycle();
                push(S_IDLE);
            end
            mask = ($urandom % 8 == 0) ? T'(0) : T'($urandom % 15 + 1);
            launch(mask);
            for (int n = 0; n < 25 && !m_done; n++) begin
                int mem;
                mem = int'($urandom % 3);
                for (int i = 0; i < T; i++) begin
                    if (m_mask[i]) b[i] = (mem != 0) ? int'($urandom % 5) : 0;
                    else b[i] = ($urandom % 2 == 0) ? 99 : int'($urandom % 4);
                end
                base = PB'($urandom);
                for (int i = 0; i < T; i++)
                    p[i] = (!m_mask[i] && $urandom % 2 == 0) ? PB'($urandom) : base;
                if ($urandom % 10 == 0) p[$urandom % T] = PB'($urandom);
                run_instr(int'($urandom % 3) + 1, mem, b, p, ($urandom % 12 == 0), 1'b0);
            end
            if (m_done) done_cycles(2);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
